byte_word_assembler: RTL and testbench

Inverse of the word-to-byte field concatenation used in our FSM test blocks: accepts a stream of 8-bit bytes and reassembles them into one wide word.
Sits between a byte-wide source (UART/byte bus model) and word-wide consumers.
Has a valid/ready handshake on both sides.
A flush input emits a partially filled word, zero-padded, together with a byte count.

---
 rtl/byte_asm_pkg.sv | 23 ++
 rtl/byte_word_assembler.sv | 122 ++++++++++++
 tb/tb_byte_word_assembler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_asm_pkg.sv
// Shared definitions for the byte-to-word assembler.
//   asm_state_t : FSM state encoding (8-bit, matches existing FSM state registers)
//   BYTE_W      : width of one incoming byte
//   slot_lo()   : low bit index of byte slot k inside the assembled word
package byte_asm_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [7:0] {
    ASM_COLLECT = 8'd0,
    ASM_HOLD    = 8'd1
  } asm_state_t;

  // Slot 0 is the first byte received. With msb_first it sits at the top of
  // the word, otherwise at the bottom.
  function automatic int slot_lo(input int k, input int msb_first, input int bytes_per_word);
    if (msb_first != 0) begin
      return (bytes_per_word - 1 - k) * BYTE_W;
    end
    return k * BYTE_W;
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Reassembles a stream of bytes into one wide word.
//
// Ports:
//   clk        system clock, all state on posedge
//   reset      asynchronous, active-high; clears all state immediately
//   in_data    incoming byte
//   in_valid   in_data is valid this cycle
//   in_ready   block can accept a byte this cycle (registered)
//   flush      single-cycle request to emit the partial word
//   out_data   assembled word, unwritten slots are zero
//   out_count  number of valid bytes in out_data (1..BYTES_PER_WORD)
//   out_valid  out_data/out_count valid
//   out_ready  consumer accepts the word
//   dbg_state  current FSM state, for observation only
//
// Handshake: a transfer happens on a posedge where valid && ready are both
// high. A producer holds its data stable while valid is high and ready is low;
// this block never drops or queues a byte it has not accepted.
//
// The assembly register doubles as out_data, so in HOLD the word is stable
// for free. A word completes or is flushed in COLLECT, the FSM moves to HOLD
// and stays there until out_ready; no byte is taken in the handshake cycle.
module byte_word_assembler
  import byte_asm_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter bit MSB_FIRST      = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [BYTE_W-1:0]                  in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               flush,
  output logic [BYTE_W*BYTES_PER_WORD-1:0]   out_data,
  output logic [3:0]                         out_count,
  output logic                               out_valid,
  input  logic                               out_ready,
  output asm_state_t                         dbg_state
);

  localparam int W  = BYTE_W * BYTES_PER_WORD;
  localparam int CW = $clog2(BYTES_PER_WORD) + 1;

  asm_state_t      state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [W-1:0]    word;
  logic [W-1:0]    word_ins;
  logic            accept;
  logic            word_full;
  logic            flush_take;

  // Byte insertion and emit decisions for the COLLECT state. cnt_next already
  // includes a byte accepted this cycle, so a flush together with a byte
  // counts that byte.
  always_comb begin
    accept   = in_valid && in_ready;
    cnt_next = cnt + CW'(accept);
    word_ins = word;
    if (accept) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (CW'(k) == cnt) begin
          word_ins[slot_lo(k, int'(MSB_FIRST), BYTES_PER_WORD) +: BYTE_W] = in_data;
        end
      end
    end
    word_full  = accept && (cnt_next == CW'(BYTES_PER_WORD));
    flush_take = flush && (cnt_next != '0);
  end

  // in_ready is registered and reset low, so nothing is accepted while reset
  // is asserted or on the cycle it releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ASM_COLLECT;
      cnt       <= '0;
      word      <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        ASM_COLLECT: begin
          cnt  <= cnt_next;
          word <= word_ins;
          if (word_full || flush_take) begin
            state     <= ASM_HOLD;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            out_count <= 4'(cnt_next);
          end else begin
            in_ready  <= 1'b1;
          end
        end
        ASM_HOLD: begin
          // flush is ignored here and not remembered.
          if (out_ready) begin
            state     <= ASM_COLLECT;
            word      <= '0;
            cnt       <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ASM_COLLECT;
          cnt       <= '0;
          word      <= '0;
          out_count <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = word;
  assign dbg_state = state;

endmodule

// File: tb/tb_byte_word_assembler.sv
// Bench for byte_word_assembler: two instances (MSB_FIRST=1 and 0) share all
// inputs. A byte-list reference model predicts every emitted word; a monitor
// compares the DUT outputs against the expected queue.
module tb_byte_word_assembler;
  import byte_asm_pkg::*;

  localparam int BPW = 4;
  localparam int W   = 8 * BPW;
  localparam int EW  = 4 + 2 * W;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         flush;
  logic         out_ready;

  logic         m_in_ready, l_in_ready;
  logic [W-1:0] m_out_data, l_out_data;
  logic [3:0]   m_out_count, l_out_count;
  logic         m_out_valid, l_out_valid;
  asm_state_t   m_state, l_state;

  int n_checks = 0;
  int n_fail   = 0;

  // expected entry = {count, msb_first word, lsb_first word}
  logic [EW-1:0] exp_q[$];

  // reference model state
  logic [7:0] mdl_bytes[$];
  logic       mdl_hold;
  logic       mdl_ready;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  byte_word_assembler #(.BYTES_PER_WORD(BPW), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .flush(flush), .out_data(m_out_data),
    .out_count(m_out_count), .out_valid(m_out_valid), .out_ready(out_ready),
    .dbg_state(m_state)
  );

  byte_word_assembler #(.BYTES_PER_WORD(BPW), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .flush(flush), .out_data(l_out_data),
    .out_count(l_out_count), .out_valid(l_out_valid), .out_ready(out_ready),
    .dbg_state(l_state)
  );

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] build_word(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < mdl_bytes.size(); k++) begin
      if (msb) w = w | (W'(mdl_bytes[k]) << (8 * (BPW - 1 - k)));
      else     w = w | (W'(mdl_bytes[k]) << (8 * k));
    end
    return w;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_bytes.delete();
      exp_q.delete();
      mdl_hold  = 1'b0;
      mdl_ready = 1'b0;
    end else begin
      if (mdl_hold) begin
        if (out_ready) mdl_hold = 1'b0;
      end else begin
        if (in_valid && mdl_ready) mdl_bytes.push_back(in_data);
        if (mdl_bytes.size() == BPW || (flush && mdl_bytes.size() > 0)) begin
          exp_q.push_back({4'(mdl_bytes.size()), build_word(1'b1), build_word(1'b0)});
          mdl_bytes.delete();
          mdl_hold = 1'b1;
        end
      end
      mdl_ready = !mdl_hold;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset) begin
      check("in_ready_msb", m_in_ready, mdl_ready);
      check("in_ready_lsb", l_in_ready, mdl_ready);
      check("out_valid_msb", m_out_valid, mdl_hold);
      check("out_valid_lsb", l_out_valid, mdl_hold);
      check("state_msb", m_state, mdl_hold ? ASM_HOLD : ASM_COLLECT);
      if (m_out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", m_out_data, '0);
          check("spurious_valid", m_out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          check("word_msb", m_out_data, e[2*W-1:W]);
          check("word_lsb", l_out_data, e[W-1:0]);
          check("count_msb", m_out_count, e[EW-1:2*W]);
          check("count_lsb", l_out_count, e[EW-1:2*W]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!m_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_out_valid || !m_in_ready) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("idle_timeout", 1'b1, 1'b0);
  endtask

  task automatic check_out(input string name, input logic [W-1:0] msbw,
                           input logic [W-1:0] lsbw, input logic [3:0] c);
    check({name, "_valid"}, m_out_valid, 1'b1);
    check({name, "_data_msb"}, m_out_data, msbw);
    check({name, "_data_lsb"}, l_out_data, lsbw);
    check({name, "_count"}, m_out_count, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    #3;
    check("rst_out_valid", m_out_valid, 1'b0);
    check("rst_out_data", m_out_data, '0);
    check("rst_out_count", m_out_count, '0);
    check("rst_in_ready", m_in_ready, 1'b0);
    check("rst_in_ready_lsb", l_in_ready, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // full word on consecutive cycles
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    check_out("full", 32'h12345678, 32'h78563412, 4'd4);
    check("full_in_ready", m_in_ready, 1'b0);
    wait_idle();

    // partial word via flush
    send_byte(8'hAB); send_byte(8'hCD);
    flush = 1'b1; tick(); flush = 1'b0;
    check_out("flush2", 32'hABCD0000, 32'h0000CDAB, 4'd2);
    wait_idle();

    // flush with nothing collected
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("empty_flush_valid", m_out_valid, 1'b0);
      tick();
    end

    // backpressure with a byte waiting at the input
    out_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", m_in_ready, 1'b0);
      check("bp_data", m_out_data, 32'h11223344);
      tick();
    end
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check_out("after_bp", 32'hEE010203, 32'h030201EE, 4'd4);
    wait_idle();

    // reset in the middle of a word
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", m_out_valid, 1'b0);
    check("midrst_in_ready", m_in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check_out("post_rst", 32'h01020304, 32'h04030201, 4'd4);
    wait_idle();

    // reset while a word is pending
    out_ready = 1'b0;
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    #2;
    reset = 1'b1;
    #1;
    check("holdrst_out_valid", m_out_valid, 1'b0);
    check("holdrst_out_count", m_out_count, '0);
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("holdrst_no_output", m_out_valid, 1'b0);
      tick();
    end

    // byte and flush in the same cycle
    send_byte(8'h55);
    in_valid = 1'b1; in_data = 8'h9A; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check_out("byte_flush", 32'h559A0000, 32'h00009A55, 4'd2);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    check("drain_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
